// File: rtl/bt_packet_decoder.sv
// Header/coordinate byte-stream decoder: command plus multi-byte X/Y with timeout, range check and valid/ready output.
// Optional trailing checksum byte is enabled by defining BT_CHECKSUM_EN.
module bt_packet_decoder #(
   parameter int COORD_W     = 6,
   parameter int CMD_W       = 3,
   parameter int X_MAX       = 63,
   parameter int Y_MAX       = 63,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx_valid,
   input  logic [7:0]         rx_byte,
   input  logic               pkt_ready,
   output logic [CMD_W-1:0]   command_id,
   output logic [COORD_W-1:0] x_out,
   output logic [COORD_W-1:0] y_out,
   output logic               pkt_valid,
   output logic               err_pulse,
   output logic [1:0]         err_code,
   output logic [7:0]         drop_cnt
);

   // state | meaning
   // S_HDR | idle, waiting for a header byte
   // S_X   | collecting X data bytes
   // S_Y   | collecting Y data bytes
   // S_CHK | waiting for the checksum byte
   typedef enum logic [1:0] {S_HDR, S_X, S_Y, S_CHK} state_t;

   localparam int NB    = (COORD_W + 5) / 6;
   localparam int ACC_W = NB * 6;
   localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [31:0] X_LIM = 32'(X_MAX);
   localparam logic [31:0] Y_LIM = 32'(Y_MAX);

   state_t             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [ACC_W-1:0]   acc_q, acc_d, acc_shift;
   logic [COORD_W-1:0] tmp_x_q, tmp_x_d, y_fin;
   logic [CMD_W-1:0]   cmd_q, cmd_d;
   logic [TO_W-1:0]    to_q, to_d;
   logic [CMD_W-1:0]   cmd_out_q, cmd_out_d;
   logic [COORD_W-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
   logic               pkt_valid_q, pkt_valid_d;
   logic               err_pulse_q, err_pulse_d;
   logic [1:0]         err_code_q, err_code_d;
   logic [7:0]         drop_q, drop_d;
   logic               is_hdr, last_idx, timeout_hit, fin, cs_bad;
   logic [5:0]         payload;
`ifdef BT_CHECKSUM_EN
   logic [5:0]         cs_q, cs_d;
   logic [COORD_W-1:0] tmp_y_q, tmp_y_d;
`endif

   assign is_hdr      = (rx_byte[7:6] == 2'b11);
   assign payload     = rx_byte[5:0];
   assign acc_shift   = ACC_W'({acc_q, payload});
   assign last_idx    = (idx_q == 3'(NB - 1));
   assign timeout_hit = (TIMEOUT_CYC != 0) && (state_q != S_HDR) && (to_q == TO_W'(TIMEOUT_CYC));

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      tmp_x_d     = tmp_x_q;
      cmd_d       = cmd_q;
      to_d        = (rx_valid || state_q == S_HDR) ? '0 : to_q + 1'b1;
      fin         = 1'b0;
      cs_bad      = 1'b0;
      y_fin       = acc_shift[COORD_W-1:0];
`ifdef BT_CHECKSUM_EN
      cs_d        = cs_q;
      tmp_y_d     = tmp_y_q;
`endif
      cmd_out_d   = cmd_out_q;
      x_out_d     = x_out_q;
      y_out_d     = y_out_q;
      pkt_valid_d = pkt_valid_q && !pkt_ready;
      err_pulse_d = 1'b0;
      err_code_d  = err_code_q;
      drop_d      = drop_q;

      if (timeout_hit) begin
         state_d     = S_HDR;
         idx_d       = '0;
         acc_d       = '0;
         err_pulse_d = 1'b1;
         err_code_d  = 2'd1;
      end else if (rx_valid) begin
         if (is_hdr) begin
            // a header always restarts the packet, even mid-packet
            cmd_d   = rx_byte[CMD_W-1:0];
            state_d = S_X;
            idx_d   = '0;
            acc_d   = '0;
`ifdef BT_CHECKSUM_EN
            cs_d    = payload;
`endif
         end else begin
            case (state_q)
               S_X: begin
                  acc_d = acc_shift;
`ifdef BT_CHECKSUM_EN
                  cs_d  = cs_q ^ payload;
`endif
                  if (last_idx) begin
                     tmp_x_d = acc_shift[COORD_W-1:0];
                     state_d = S_Y;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end
               S_Y: begin
                  acc_d = acc_shift;
`ifdef BT_CHECKSUM_EN
                  cs_d  = cs_q ^ payload;
`endif
                  if (last_idx) begin
                     idx_d = '0;
`ifdef BT_CHECKSUM_EN
                     tmp_y_d = acc_shift[COORD_W-1:0];
                     state_d = S_CHK;
`else
                     fin     = 1'b1;
                     state_d = S_HDR;
`endif
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end
`ifdef BT_CHECKSUM_EN
               S_CHK: begin
                  state_d = S_HDR;
                  y_fin   = tmp_y_q;
                  if (payload == cs_q) fin = 1'b1;
                  else                 cs_bad = 1'b1;
               end
`endif
               default: ;
            endcase
         end
      end

      if (cs_bad) begin
         err_pulse_d = 1'b1;
         err_code_d  = 2'd3;
      end else if (fin) begin
         if (32'(tmp_x_q) > X_LIM || 32'(y_fin) > Y_LIM) begin
            err_pulse_d = 1'b1;
            err_code_d  = 2'd2;
         end else if (!pkt_valid_q || pkt_ready) begin
            cmd_out_d   = cmd_q;
            x_out_d     = tmp_x_q;
            y_out_d     = y_fin;
            pkt_valid_d = 1'b1;
         end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_HDR;
         idx_q       <= '0;
         acc_q       <= '0;
         tmp_x_q     <= '0;
         cmd_q       <= '0;
         to_q        <= '0;
         cmd_out_q   <= '0;
         x_out_q     <= '0;
         y_out_q     <= '0;
         pkt_valid_q <= 1'b0;
         err_pulse_q <= 1'b0;
         err_code_q  <= 2'd0;
         drop_q      <= 8'd0;
`ifdef BT_CHECKSUM_EN
         cs_q        <= '0;
         tmp_y_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         tmp_x_q     <= tmp_x_d;
         cmd_q       <= cmd_d;
         to_q        <= to_d;
         cmd_out_q   <= cmd_out_d;
         x_out_q     <= x_out_d;
         y_out_q     <= y_out_d;
         pkt_valid_q <= pkt_valid_d;
         err_pulse_q <= err_pulse_d;
         err_code_q  <= err_code_d;
         drop_q      <= drop_d;
`ifdef BT_CHECKSUM_EN
         cs_q        <= cs_d;
         tmp_y_q     <= tmp_y_d;
`endif
      end
   end

   assign command_id = cmd_out_q;
   assign x_out      = x_out_q;
   assign y_out      = y_out_q;
   assign pkt_valid  = pkt_valid_q;
   assign err_pulse  = err_pulse_q;
   assign err_code   = err_code_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_bt_packet_decoder.sv
// Bench for bt_packet_decoder: instance A (6-bit coords, X_MAX=31, timeout 8) and B (8-bit coords, Y_MAX=150).
// Honours BT_CHECKSUM_EN by appending the checksum byte to every full packet.
module tb_bt_packet_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_v [2];
   logic [7:0] i_b [2];
   logic       i_r [2];

   logic [2:0] o_cmd [2];
   logic       o_pv  [2];
   logic       o_ep  [2];
   logic [1:0] o_ec  [2];
   logic [7:0] o_dc  [2];
   logic [7:0] o_x   [2];
   logic [7:0] o_y   [2];
   logic [5:0] x_a, y_a;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bt_packet_decoder #(.COORD_W(6), .CMD_W(3), .X_MAX(31), .Y_MAX(63), .TIMEOUT_CYC(8)) dut_a (
      .clk(clk), .reset(rst_n), .rx_valid(i_v[0]), .rx_byte(i_b[0]), .pkt_ready(i_r[0]),
      .command_id(o_cmd[0]), .x_out(x_a), .y_out(y_a), .pkt_valid(o_pv[0]),
      .err_pulse(o_ep[0]), .err_code(o_ec[0]), .drop_cnt(o_dc[0]));

   bt_packet_decoder #(.COORD_W(8), .CMD_W(3), .X_MAX(255), .Y_MAX(150), .TIMEOUT_CYC(20)) dut_b (
      .clk(clk), .reset(rst_n), .rx_valid(i_v[1]), .rx_byte(i_b[1]), .pkt_ready(i_r[1]),
      .command_id(o_cmd[1]), .x_out(o_x[1]), .y_out(o_y[1]), .pkt_valid(o_pv[1]),
      .err_pulse(o_ep[1]), .err_code(o_ec[1]), .drop_cnt(o_dc[1]));

   assign o_x[0] = {2'b00, x_a};
   assign o_y[0] = {2'b00, y_a};

   // Drive each byte for one cycle; rl >= 0 sets pkt_ready alongside the final byte.
   task automatic send_q(input int b, input logic [7:0] q[$], input int rl, input int gap);
      for (int i = 0; i < q.size(); i++) begin
         if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
         @(negedge clk);
         i_v[b] = 1'b1;
         i_b[b] = q[i];
         if (i == q.size() - 1 && rl >= 0) i_r[b] = rl[0];
         @(posedge clk);
         #1;
         i_v[b] = 1'b0;
      end
   endtask

   task automatic send_pkt(input int b, input logic [7:0] q[$], input int rl, input int gap);
      logic [7:0] qq[$];
      logic [5:0] cs;
      qq = q;
      cs = 6'd0;
`ifdef BT_CHECKSUM_EN
      foreach (qq[i]) begin
         if (qq[i][7:6] == 2'b11) cs = qq[i][5:0];
         else                     cs = cs ^ qq[i][5:0];
      end
      qq.push_back({2'b00, cs});
`endif
      send_q(b, qq, rl, gap);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_pkt(input string nm, input int b, input logic [2:0] c, input logic [7:0] x, input logic [7:0] y);
      n_chk++;
      if ({o_pv[b], o_ep[b], o_cmd[b], o_x[b], o_y[b]} !== {1'b1, 1'b0, c, x, y}) begin
         n_fail++;
         $display("FAIL %s: got pv=%0b ep=%0b cmd=%0d x=%0d y=%0d, want pv=1 ep=0 cmd=%0d x=%0d y=%0d",
                  nm, o_pv[b], o_ep[b], o_cmd[b], o_x[b], o_y[b], c, x, y);
      end
   endtask

   task automatic chk_err(input string nm, input int b, input logic [1:0] code);
      n_chk++;
      if ({o_ep[b], o_ec[b], o_pv[b]} !== {1'b1, code, 1'b0}) begin
         n_fail++;
         $display("FAIL %s: got ep=%0b ec=%0d pv=%0b, want ep=1 ec=%0d pv=0", nm, o_ep[b], o_ec[b], o_pv[b], code);
      end
   endtask

   task automatic chk_bit(input string nm, input logic got, input logic want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0b, want %0b", nm, got, want);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int b = 0; b < 2; b++) begin
         i_v[b] = 1'b0; i_b[b] = 8'h00; i_r[b] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int b = 0; b < 2; b++) begin
         n_chk++;
         if ({o_pv[b], o_ep[b], o_ec[b], o_dc[b], o_cmd[b], o_x[b], o_y[b]} !== '0) begin
            n_fail++;
            $display("FAIL reset[%0d]: pv=%0b ep=%0b ec=%0d dc=%0d cmd=%0d x=%0d y=%0d, want all 0",
                     b, o_pv[b], o_ep[b], o_ec[b], o_dc[b], o_cmd[b], o_x[b], o_y[b]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [7:0] q[$];
      i_r[0] = 1'b1;
      q = {};
      q.push_back(8'hC1); q.push_back(8'h0A); q.push_back(8'h14);
      send_pkt(0, q, -1, 0);
      chk_pkt("basic", 0, 3'd1, 8'd10, 8'd20);
      step();
      chk_bit("basic_handshake_drop", o_pv[0], 1'b0);
   endtask

   task automatic test_multibyte();
      logic [7:0] q[$];
      i_r[1] = 1'b1;
      q = {};
      q.push_back(8'hC2); q.push_back(8'h03); q.push_back(8'h3F); q.push_back(8'h00); q.push_back(8'h05);
      send_pkt(1, q, -1, 0);
      chk_pkt("multibyte", 1, 3'd2, 8'hFF, 8'h05);
      step();
      chk_bit("multibyte_drop", o_pv[1], 1'b0);
   endtask

   task automatic test_resync();
      logic [7:0] q[$];
      q = {};
      q.push_back(8'hC1); q.push_back(8'h0A);
      send_q(0, q, -1, 0);
      q = {};
      q.push_back(8'hC3); q.push_back(8'h01); q.push_back(8'h02);
      send_pkt(0, q, -1, 0);
      chk_pkt("resync", 0, 3'd3, 8'd1, 8'd2);
      n_chk++;
      if (o_ec[0] !== 2'd0) begin
         n_fail++;
         $display("FAIL resync_no_error: ec=%0d, want 0", o_ec[0]);
      end
      step();
   endtask

   task automatic test_range();
      logic [7:0] q[$];
      q = {};
      q.push_back(8'hC1); q.push_back(8'h28); q.push_back(8'h01);
      send_pkt(0, q, -1, 0);
      chk_err("range_x", 0, 2'd2);
      step();
      chk_bit("range_pulse_one_cycle", o_ep[0], 1'b0);
   endtask

   task automatic test_timeout();
      logic [7:0] q[$];
      int hit;
      q = {};
      q.push_back(8'hC1); q.push_back(8'h0A);
      send_q(0, q, -1, 0);
      hit = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (o_ep[0] === 1'b1) begin
            hit = k;
            break;
         end
      end
      n_chk++;
      if (hit < 8 || hit > 9) begin
         n_fail++;
         $display("FAIL timeout_latency: pulse after %0d idle cycles, want 8..9 (0 = none within 20)", hit);
      end
      n_chk++;
      if ({o_ec[0], o_pv[0]} !== {2'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL timeout_code: ec=%0d pv=%0b, want ec=1 pv=0", o_ec[0], o_pv[0]);
      end
      q = {};
      q.push_back(8'hC1); q.push_back(8'h05); q.push_back(8'h06);
      send_pkt(0, q, -1, 0);
      chk_pkt("after_timeout", 0, 3'd1, 8'd5, 8'd6);
      step();
   endtask

   task automatic test_back_to_back();
      logic [7:0] q[$];
      i_r[0] = 1'b0;
      q = {};
      q.push_back(8'hC2); q.push_back(8'h01); q.push_back(8'h02);
      send_pkt(0, q, -1, 0);
      chk_pkt("b2b_first", 0, 3'd2, 8'd1, 8'd2);
      q = {};
      q.push_back(8'hC3); q.push_back(8'h03); q.push_back(8'h04);
      send_pkt(0, q, -1, 0);
      chk_pkt("b2b_held", 0, 3'd2, 8'd1, 8'd2);
      n_chk++;
      if (o_dc[0] !== 8'd1) begin
         n_fail++;
         $display("FAIL b2b_drop_cnt: got %0d, want 1", o_dc[0]);
      end
      // handshake in the same cycle as a completion replaces the held packet
      q = {};
      q.push_back(8'hC1); q.push_back(8'h07); q.push_back(8'h08);
      send_pkt(0, q, 1, 0);
      chk_pkt("b2b_replace", 0, 3'd1, 8'd7, 8'd8);
      n_chk++;
      if (o_dc[0] !== 8'd1) begin
         n_fail++;
         $display("FAIL b2b_replace_drop_cnt: got %0d, want 1", o_dc[0]);
      end
      step();
      chk_bit("b2b_release", o_pv[0], 1'b0);
   endtask

`ifdef BT_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] q[$];
      i_r[0] = 1'b1;
      q = {};
      q.push_back(8'hC1); q.push_back(8'h0A); q.push_back(8'h14); q.push_back(8'h1F);
      send_q(0, q, -1, 0);
      chk_pkt("cs_good", 0, 3'd1, 8'd10, 8'd20);
      step();
      q[3] = 8'h1E;
      send_q(0, q, -1, 0);
      chk_err("cs_bad", 0, 2'd3);
      step();
      q = {};
      q.push_back(8'hC1); q.push_back(8'h28); q.push_back(8'h01); q.push_back(8'h28);
      send_q(0, q, -1, 0);
      chk_err("cs_then_range", 0, 2'd2);
      step();
   endtask
`endif

   // Random packets on B, each optionally preceded by stray data and an abandoned partial packet.
   task automatic test_random();
      logic [7:0] q[$];
      logic [7:0] hdr;
      int p[4];
      int xe, ye;
      i_r[1] = 1'b1;
      for (int n = 0; n < 60; n++) begin
         q = {};
         if ($urandom_range(0, 2) == 0) begin
            q.push_back(8'(($urandom_range(0, 2) << 6) | $urandom_range(0, 63)));
            q.push_back(8'hC0 | 8'($urandom_range(0, 63)));
            repeat ($urandom_range(0, 3)) q.push_back(8'($urandom_range(0, 63)));
            send_q(1, q, -1, 3);
         end
         hdr = 8'hC0 | 8'($urandom_range(0, 63));
         q = {};
         q.push_back(hdr);
         for (int k = 0; k < 4; k++) begin
            p[k] = int'($urandom_range(0, 63));
            q.push_back(8'(($urandom_range(0, 2) << 6) | p[k]));
         end
         send_pkt(1, q, -1, 4);
         xe = (p[0] * 64 + p[1]) % 256;
         ye = (p[2] * 64 + p[3]) % 256;
         if (ye > 150) chk_err($sformatf("rand_range_%0d", n), 1, 2'd2);
         else          chk_pkt($sformatf("rand_pkt_%0d", n), 1, hdr[2:0], 8'(xe), 8'(ye));
         step();
         chk_bit($sformatf("rand_idle_%0d", n), o_pv[1], 1'b0);
      end
      n_chk++;
      if (o_dc[1] !== 8'd0) begin
         n_fail++;
         $display("FAIL rand_drop_cnt: got %0d, want 0", o_dc[1]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_multibyte();
      test_resync();
      test_range();
      test_timeout();
      test_back_to_back();
`ifdef BT_CHECKSUM_EN
      test_checksum();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
